// File: rtl/hsst_tx_line_framer_pkg.sv
// rtl/hsst_tx_line_framer_pkg.sv - K-character bytes, link words, FSM states and word builders shared by the framer
package hsst_tx_line_framer_pkg;

   localparam logic [7:0] K_BC = 8'hBC;
   localparam logic [7:0] K_FB = 8'hFB;
   localparam logic [7:0] K_FD = 8'hFD;
   localparam logic [7:0] K_1C = 8'h1C;
   localparam logic [7:0] K_50 = 8'h50;

   localparam logic [31:0] IDLE_WORD = {K_50, K_50, K_50, K_BC};
   localparam logic [31:0] FILL_WORD = {K_1C, K_1C, K_1C, K_BC};
   localparam logic [3:0]  K_CTRL    = 4'b0001;
   localparam logic [3:0]  K_DATA    = 4'b0000;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_SOF     = 2'd1,
      ST_PAYLOAD = 2'd2,
      ST_EOF     = 2'd3
   } state_t;

   // Frame-start flag marks line 0 so the receiver can realign to the frame
   function automatic logic [31:0] sof_word(input logic [11:0] line);
      return {(line == 12'd0), 3'b000, line, K_FB, K_BC};
   endfunction

   function automatic logic [31:0] eof_word(input logic [15:0] csum);
      return {csum, K_FD, K_BC};
   endfunction

   function automatic logic [15:0] csum_add(input logic [15:0] csum, input logic [31:0] data);
      return csum + data[31:16] + data[15:0];
   endfunction

endpackage

// File: rtl/hsst_tx_line_framer.sv
// rtl/hsst_tx_line_framer.sv - wraps each video line from the prefetch FIFO into an SOF/payload/EOF packet with comma fill
module hsst_tx_line_framer
   import hsst_tx_line_framer_pkg::*;
#(
   parameter int unsigned LINE_WORDS  = 960,
   parameter int unsigned FRAME_LINES = 1080,
   parameter int unsigned IDLE_MIN    = 4
)(
   input  logic        i_clk,
   input  logic        i_rst,
   input  logic        i_tx_en,
   input  logic [31:0] i_fifo_rd_data,
   input  logic        i_fifo_rd_vld,
   output logic        o_fifo_rd_en,
   output logic [31:0] o_tx_data,
   output logic [3:0]  o_tx_k,
   output logic        o_busy,
   output logic [15:0] o_underrun_cnt
);

   localparam logic [15:0] LAST_WORD  = 16'(LINE_WORDS - 1);
   localparam logic [11:0] LAST_LINE  = 12'(FRAME_LINES - 1);
   localparam logic [7:0]  IDLE_MIN_C = 8'(IDLE_MIN);

   state_t      r_state;
   logic [11:0] r_line;
   logic [7:0]  r_idle_cnt;
   logic [15:0] r_word_cnt;
   logic [15:0] r_csum;
   logic [31:0] r_tx_data;
   logic [3:0]  r_tx_k;
   logic        r_busy;
   logic [15:0] r_underrun_cnt;

   state_t      w_state_nxt;
   logic [11:0] w_line_nxt;
   logic [7:0]  w_idle_nxt;
   logic [15:0] w_word_nxt;
   logic [15:0] w_csum_nxt;
   logic [31:0] w_tx_data;
   logic [3:0]  w_tx_k;
   logic [15:0] w_underrun_nxt;
   logic        w_rd_en;

   always_comb begin
      w_state_nxt    = r_state;
      w_line_nxt     = r_line;
      w_idle_nxt     = r_idle_cnt;
      w_word_nxt     = r_word_cnt;
      w_csum_nxt     = r_csum;
      w_tx_data      = IDLE_WORD;
      w_tx_k         = K_CTRL;
      w_underrun_nxt = r_underrun_cnt;
      w_rd_en        = 1'b0;
      case (r_state)
         ST_IDLE: begin
            if (r_idle_cnt < IDLE_MIN_C)
               w_idle_nxt = r_idle_cnt + 8'd1;
            if (i_tx_en && i_fifo_rd_vld && (r_idle_cnt >= IDLE_MIN_C))
               w_state_nxt = ST_SOF;
         end
         ST_SOF: begin
            w_tx_data   = sof_word(r_line);
            w_word_nxt  = 16'd0;
            w_csum_nxt  = 16'd0;
            w_state_nxt = ST_PAYLOAD;
         end
         ST_PAYLOAD: begin
            w_rd_en = 1'b1;
            if (i_fifo_rd_vld) begin
               w_tx_data  = i_fifo_rd_data;
               w_tx_k     = K_DATA;
               w_csum_nxt = csum_add(r_csum, i_fifo_rd_data);
               w_word_nxt = r_word_cnt + 16'd1;
               if (r_word_cnt == LAST_WORD)
                  w_state_nxt = ST_EOF;
            end else begin
               // Empty FIFO mid-line: hold the packet open with commas rather than truncating it
               w_tx_data = FILL_WORD;
               if (r_underrun_cnt != 16'hFFFF)
                  w_underrun_nxt = r_underrun_cnt + 16'd1;
            end
         end
         ST_EOF: begin
            w_tx_data   = eof_word(r_csum);
            w_line_nxt  = (r_line == LAST_LINE) ? 12'd0 : r_line + 12'd1;
            w_idle_nxt  = 8'd0;
            w_state_nxt = ST_IDLE;
         end
         default: w_state_nxt = ST_IDLE;
      endcase
   end

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_state        <= ST_IDLE;
         r_line         <= 12'd0;
         r_idle_cnt     <= 8'd0;
         r_word_cnt     <= 16'd0;
         r_csum         <= 16'd0;
         r_tx_data      <= IDLE_WORD;
         r_tx_k         <= K_CTRL;
         r_busy         <= 1'b0;
         r_underrun_cnt <= 16'd0;
      end else begin
         r_state        <= w_state_nxt;
         r_line         <= w_line_nxt;
         r_idle_cnt     <= w_idle_nxt;
         r_word_cnt     <= w_word_nxt;
         r_csum         <= w_csum_nxt;
         r_tx_data      <= w_tx_data;
         r_tx_k         <= w_tx_k;
         r_busy         <= (w_state_nxt != ST_IDLE);
         r_underrun_cnt <= w_underrun_nxt;
      end
   end

   assign o_fifo_rd_en   = w_rd_en;
   assign o_tx_data      = r_tx_data;
   assign o_tx_k         = r_tx_k;
   assign o_busy         = r_busy;
   assign o_underrun_cnt = r_underrun_cnt;

endmodule

// File: tb/tb_hsst_tx_line_framer.sv
// tb/tb_hsst_tx_line_framer.sv - vector table plus FIFO/stream-grammar reference checks for hsst_tx_line_framer
module tb_hsst_tx_line_framer;

   localparam int LW = 4;
   localparam int FL = 2;
   localparam int IM = 2;

   localparam logic [31:0] IDLE_W = 32'h5050_50BC;
   localparam logic [31:0] FILL_W = 32'h1C1C_1CBC;

   logic        i_clk = 1'b0;
   logic        i_rst = 1'b1;
   logic        i_tx_en = 1'b0;
   logic [31:0] i_fifo_rd_data = 32'd0;
   logic        i_fifo_rd_vld = 1'b0;
   logic        o_fifo_rd_en;
   logic [31:0] o_tx_data;
   logic [3:0]  o_tx_k;
   logic        o_busy;
   logic [15:0] o_underrun_cnt;

   hsst_tx_line_framer #(.LINE_WORDS(LW), .FRAME_LINES(FL), .IDLE_MIN(IM)) dut (
      .i_clk(i_clk), .i_rst(i_rst), .i_tx_en(i_tx_en),
      .i_fifo_rd_data(i_fifo_rd_data), .i_fifo_rd_vld(i_fifo_rd_vld),
      .o_fifo_rd_en(o_fifo_rd_en), .o_tx_data(o_tx_data), .o_tx_k(o_tx_k),
      .o_busy(o_busy), .o_underrun_cnt(o_underrun_cnt)
   );

   always #5 i_clk = ~i_clk;

   int total = 0;
   int bad = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h want %0h", name, act, exp);
      end
   endtask

   // FIFO model and output log
   logic [31:0] q[$];
   logic [31:0] exp_pay[$];
   logic [31:0] log_d[$];
   logic [3:0]  log_k[$];
   logic [31:0] sof_log[$];
   logic [31:0] eof_log[$];
   int pops, drop_after, stall_at, stall_len, stall_rem;
   bit tx_gate, rnd_stall;

   task automatic push(input logic [31:0] w);
      q.push_back(w);
      exp_pay.push_back(w);
   endtask

   task automatic do_reset();
      i_rst = 1'b1;
      i_tx_en = 1'b0;
      i_fifo_rd_vld = 1'b0;
      repeat (2) @(posedge i_clk);
      #1;
      chk("rst_tx_data", o_tx_data, IDLE_W);
      chk("rst_tx_k", o_tx_k, 4'b0001);
      chk("rst_rd_en", o_fifo_rd_en, 1'b0);
      chk("rst_busy", o_busy, 1'b0);
      chk("rst_underrun", o_underrun_cnt, 16'd0);
      q.delete(); exp_pay.delete(); log_d.delete(); log_k.delete();
      sof_log.delete(); eof_log.delete();
      pops = 0; drop_after = -1; stall_at = -1; stall_len = 0; stall_rem = 0;
      tx_gate = 1'b1; rnd_stall = 1'b0;
      i_rst = 1'b0;
   endtask

   task automatic run(input int n);
      bit st, pop;
      for (int c = 0; c < n; c++) begin
         if (stall_rem > 0) st = 1'b1;
         else if (rnd_stall) st = ($urandom_range(0, 3) == 0);
         else st = 1'b0;
         i_tx_en = tx_gate && !(drop_after >= 0 && pops >= drop_after);
         i_fifo_rd_vld = (q.size() > 0) && !st;
         i_fifo_rd_data = i_fifo_rd_vld ? q[0] : $urandom;
         #0;
         pop = o_fifo_rd_en && i_fifo_rd_vld;
         @(posedge i_clk);
         #1;
         if (st && stall_rem > 0) stall_rem--;
         if (pop) begin
            void'(q.pop_front());
            pops++;
            if (pops == stall_at) stall_rem = stall_len;
         end
         log_d.push_back(o_tx_data);
         log_k.push_back(o_tx_k);
      end
   endtask

   // Stream grammar: IDLE* SOF (payload|FILL)* EOF ..., payload in FIFO order
   task automatic check_stream(input int exp_pkts, output int fills);
      int in_pkt = 0, pk = 0, gap = 0, pi = 0, cnt = 0, m_line = 0;
      logic [15:0] sum;
      logic [31:0] d;
      logic [3:0] k;
      fills = 0;
      sum = 16'd0;
      for (int i = 0; i < log_d.size(); i++) begin
         d = log_d[i];
         k = log_k[i];
         if (in_pkt == 0) begin
            if (d == IDLE_W && k == 4'b0001) gap++;
            else if (k == 4'b0001 && d[15:0] == 16'hFBBC) begin
               chk("gap_min", (gap >= IM), 1'b1);
               chk("sof_word", d, {(m_line == 0), 3'b000, 12'(m_line), 16'hFBBC});
               sof_log.push_back(d);
               in_pkt = 1; cnt = 0; sum = 16'd0;
            end else chk("idle_word", {k, d}, {4'b0001, IDLE_W});
         end else begin
            if (k == 4'b0000) begin
               if (pi < exp_pay.size()) chk("payload", d, exp_pay[pi]);
               else chk("payload_extra", pi, exp_pay.size());
               sum = 16'((sum + (d >> 16) + (d & 32'hFFFF)) % 65536);
               pi++; cnt++;
            end else if (d == FILL_W && k == 4'b0001) fills++;
            else if (k == 4'b0001 && d[15:0] == 16'hFDBC) begin
               chk("pkt_len", cnt, LW);
               chk("eof_word", d, {sum, 16'hFDBC});
               eof_log.push_back(d);
               m_line = (m_line == FL - 1) ? 0 : m_line + 1;
               pk++; gap = 0; in_pkt = 0;
            end else chk("pkt_word", {k, d}, {4'b0001, FILL_W});
         end
      end
      chk("pkt_count", pk, exp_pkts);
      chk("ends_idle", in_pkt, 0);
   endtask

   typedef struct {
      logic        tx_en;
      logic        vld;
      logic [31:0] data;
      logic        exp_rd_en;
      logic        exp_busy;
      logic [31:0] exp_data;
      logic [3:0]  exp_k;
   } vec_t;

   vec_t vecs[10];
   int fills;

   initial begin
      vecs[0] = '{1, 1, 32'h00010002, 0, 0, IDLE_W,        4'b0001};
      vecs[1] = '{1, 1, 32'h00010002, 0, 0, IDLE_W,        4'b0001};
      vecs[2] = '{1, 1, 32'h00010002, 0, 0, IDLE_W,        4'b0001};
      vecs[3] = '{1, 1, 32'h00010002, 0, 1, 32'h8000FBBC,  4'b0001};
      vecs[4] = '{1, 1, 32'h00010002, 1, 1, 32'h00010002,  4'b0000};
      vecs[5] = '{1, 1, 32'h00030004, 1, 1, 32'h00030004,  4'b0000};
      vecs[6] = '{1, 1, 32'h00050006, 1, 1, 32'h00050006,  4'b0000};
      vecs[7] = '{1, 1, 32'h00070008, 1, 1, 32'h00070008,  4'b0000};
      vecs[8] = '{0, 0, 32'h00000000, 0, 1, 32'h0024FDBC,  4'b0001};
      vecs[9] = '{0, 0, 32'h00000000, 0, 0, IDLE_W,        4'b0001};

      // Reset state, then exact cycle trace of one packet
      do_reset();
      for (int i = 0; i < 10; i++) begin
         i_tx_en = vecs[i].tx_en;
         i_fifo_rd_vld = vecs[i].vld;
         i_fifo_rd_data = vecs[i].data;
         #0;
         chk($sformatf("vec%0d_rd_en", i), o_fifo_rd_en, vecs[i].exp_rd_en);
         chk($sformatf("vec%0d_busy", i), o_busy, vecs[i].exp_busy);
         @(posedge i_clk);
         #1;
         chk($sformatf("vec%0d_word", i), {o_tx_k, o_tx_data}, {vecs[i].exp_k, vecs[i].exp_data});
      end

      // FIFO underrun for 3 cycles after word 2
      do_reset();
      for (int i = 0; i < 4; i++) push({16'(2 * i + 1), 16'(2 * i + 2)});
      stall_at = 2; stall_len = 3;
      run(20);
      check_stream(1, fills);
      chk("fill_count", fills, 3);
      chk("underrun_cnt", o_underrun_cnt, 16'd3);
      if (eof_log.size() > 0) chk("fill_eof", eof_log[0], 32'h0024FDBC);

      // Three back-to-back packets, line wrap
      do_reset();
      for (int i = 0; i < 3 * LW; i++) push($urandom);
      run(40);
      check_stream(3, fills);
      if (sof_log.size() == 3) begin
         chk("sof0", sof_log[0], 32'h8000FBBC);
         chk("sof1", sof_log[1], 32'h0001FBBC);
         chk("sof2", sof_log[2], 32'h8000FBBC);
      end else chk("sof_log_size", sof_log.size(), 3);

      // tx_en dropped mid-packet
      do_reset();
      for (int i = 0; i < 2 * LW; i++) push($urandom);
      drop_after = 1;
      run(40);
      check_stream(1, fills);
      chk("drop_fifo_left", q.size(), LW);
      chk("drop_pops", pops, LW);
      chk("drop_rd_en", o_fifo_rd_en, 1'b0);
      chk("drop_busy", o_busy, 1'b0);

      // Checksum wrap
      do_reset();
      for (int i = 0; i < LW; i++) push(32'hFFFFFFFF);
      run(15);
      check_stream(1, fills);
      if (eof_log.size() > 0) chk("wrap_eof", eof_log[0], 32'hFFF8FDBC);

      // Async reset mid-payload, next packet restarts at line 0
      do_reset();
      for (int i = 0; i < 2 * LW; i++) push($urandom);
      run(10);
      run(6);
      #3;
      i_rst = 1'b1;
      #1;
      chk("arst_tx_data", o_tx_data, IDLE_W);
      chk("arst_busy", o_busy, 1'b0);
      chk("arst_rd_en", o_fifo_rd_en, 1'b0);
      do_reset();
      for (int i = 0; i < LW; i++) push($urandom);
      run(15);
      check_stream(1, fills);
      if (sof_log.size() > 0) chk("arst_sof", sof_log[0], 32'h8000FBBC);

      // Randomized traffic with random FIFO stalls
      for (int r = 0; r < 4; r++) begin
         do_reset();
         rnd_stall = 1'b1;
         for (int i = 0; i < 3 * LW; i++) push($urandom);
         run(80);
         check_stream(3, fills);
         chk("rnd_underrun", o_underrun_cnt, 16'(fills));
         chk("rnd_fifo_empty", q.size(), 0);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
